// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
package bpu_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_RET  = 2'b10,
    BR_NONE = 2'b11
  } br_type_e;

  // Index width for a power-of-two table; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Weakly not-taken counter value.
  function automatic int ctr_init(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return address stack: overflow overwrites the oldest entry,
// pop on empty is ignored, simultaneous push+pop replaces the top.
module bpu_ras
  import bpu_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty
);

  localparam int PW = idx_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [AW-1:0] stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_ptr;
  logic [PW:0]   cnt;
  logic          do_pop;

  assign top_ptr = ptr - PW'(1);
  assign empty   = (cnt == '0);
  assign top     = stack[top_ptr];
  assign do_pop  = pop && !empty;

  // ptr addresses the next free slot; at full it addresses the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (do_pop && !push) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW + 1)'(1);
    end else if (push && !do_pop) begin
      ptr <= ptr + PW'(1);
      if (cnt != FULL_CNT) cnt <= cnt + (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[do_pop ? top_ptr : ptr] <= push_data;
  end

endmodule

// File: rtl/bpu_predictor.sv
// Branch prediction unit: direct-mapped BTB, saturating-counter BHT with
// optional gshare indexing, return stack and saturating perf counters.
module bpu_predictor
  import bpu_pkg::*;
#(
  parameter int AW          = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int TAG_BITS    = 10,
  parameter int BHT_ENTRIES = 256,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 0,
  parameter int RAS_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_f,
  output logic          pred_taken_f,
  output logic [AW-1:0] pred_target_f,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_pc,
  input  logic [1:0]    upd_type,
  input  logic          upd_call,
  input  logic          upd_taken,
  input  logic [AW-1:0] upd_target,
  input  logic          upd_mispredict,
  output logic [31:0]   perf_branches,
  output logic [31:0]   perf_mispredicts
);

  localparam int IDX_W  = idx_w(BTB_ENTRIES);
  localparam int BIDX_W = idx_w(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                   input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic                btb_valid [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag   [BTB_ENTRIES];
  logic [AW-1:0]       btb_tgt   [BTB_ENTRIES];
  br_type_e            btb_type  [BTB_ENTRIES];
  logic [CTR_BITS-1:0] bht       [BHT_ENTRIES];

  logic [IDX_W-1:0]    idx_f, idx_u;
  logic [TAG_BITS-1:0] tag_f, tag_u;
  logic [BIDX_W-1:0]   bidx_f, bidx_u, ghr_ext;
  logic                hit_f, hit_u;
  br_type_e            type_f;
  logic [CTR_BITS-1:0] ctr_f;
  logic                ras_empty;
  logic [AW-1:0]       ras_top;
  logic                upd_cond, btb_we, ras_push, ras_pop;

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr <= '0;
        else if (upd_cond) ghr <= (ghr << 1) | GHR_BITS'(upd_taken);
      end
      assign ghr_ext = BIDX_W'(ghr);
    end else begin : g_no_ghr
      assign ghr_ext = '0;
    end
  endgenerate

  // Fetch-side lookup, purely combinational on pre-update state
  assign idx_f  = pc_f[IDX_W-1:0];
  assign tag_f  = pc_f[IDX_W+TAG_BITS-1:IDX_W];
  assign bidx_f = pc_f[BIDX_W-1:0] ^ ghr_ext;
  assign hit_f  = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
  assign type_f = btb_type[idx_f];
  assign ctr_f  = bht[bidx_f];

  always_comb begin
    pred_taken_f = 1'b0;
    if (hit_f) begin
      case (type_f)
        BR_JUMP: pred_taken_f = 1'b1;
        BR_COND: pred_taken_f = ctr_f[CTR_BITS-1];
        BR_RET:  pred_taken_f = !ras_empty;
        default: pred_taken_f = 1'b0;
      endcase
    end
    pred_target_f = pc_f + AW'(1);
    if (pred_taken_f) pred_target_f = (type_f == BR_RET) ? ras_top : btb_tgt[idx_f];
  end

  // Resolution-side training
  assign idx_u    = upd_pc[IDX_W-1:0];
  assign tag_u    = upd_pc[IDX_W+TAG_BITS-1:IDX_W];
  assign bidx_u   = upd_pc[BIDX_W-1:0] ^ ghr_ext;
  assign hit_u    = btb_valid[idx_u] && (btb_tag[idx_u] == tag_u);
  assign upd_cond = upd_valid && (upd_type == BR_COND);
  assign btb_we   = upd_valid && (upd_type != BR_NONE) && (upd_taken || hit_u);
  assign ras_push = upd_valid && upd_call;
  assign ras_pop  = upd_valid && (upd_type == BR_RET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid[idx_u] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[idx_u]  <= tag_u;
      btb_tgt[idx_u]  <= upd_target;
      btb_type[idx_u] <= br_type_e'(upd_type);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RST;
    end else if (upd_cond) begin
      bht[bidx_u] <= ctr_next(bht[bidx_u], upd_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd_cond) perf_branches <= sat_inc32(perf_branches);
      if (upd_valid && upd_mispredict) perf_mispredicts <= sat_inc32(perf_mispredicts);
    end
  end

  bpu_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (upd_pc + AW'(1)),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_bpu_predictor.sv
// Directed bench for bpu_predictor with default parameters.
module tb_bpu_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_call;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] T_COND = 2'b00;
  localparam logic [1:0] T_JUMP = 2'b01;
  localparam logic [1:0] T_RET  = 2'b10;
  localparam logic [1:0] T_NONE = 2'b11;

  bpu_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_f             (pc_f),
    .pred_taken_f     (pred_taken_f),
    .pred_target_f    (pred_target_f),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_type         (upd_type),
    .upd_call         (upd_call),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic look(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt,
                      input string tag);
    pc_f = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken_f}, {31'd0, exp_tk});
    chk({tag, "_target"}, pred_target_f, exp_tgt);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [1:0] ty, input logic call,
                         input logic tk, input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_type = ty; upd_call = call;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] ty, input logic call,
                     input logic tk, input logic [31:0] tgt, input logic mis);
    set_upd(pc, ty, call, tk, tgt, mis);
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_call = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_f = '0; upd_valid = 1'b0; upd_pc = '0; upd_type = T_NONE;
    upd_call = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    #12;
    chk("rst_perf_br", perf_branches, 32'd0);
    chk("rst_perf_mis", perf_mispredicts, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) look(i, 1'b0, i + 1, "sweep");

    // Branch at 0x40: counter 1 -> 2 (taken), lookup reads old state in the update cycle
    pc_f = 32'h40;
    set_upd(32'h40, T_COND, 1'b0, 1'b1, 32'h10, 1'b1);
    #1;
    chk("same_cycle_old", {31'd0, pred_taken_f}, 32'd0);
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    look(32'h40, 1'b1, 32'h10, "br_t1");
    upd(32'h40, T_COND, 1'b0, 1'b0, 32'h10, 1'b1);
    look(32'h40, 1'b0, 32'h41, "br_nt1");

    // Saturation: 1 -> 3 after five taken, then 2 (taken), then 1 (not taken)
    for (int i = 0; i < 5; i++) upd(32'h40, T_COND, 1'b0, 1'b1, 32'h10, 1'b0);
    look(32'h40, 1'b1, 32'h10, "sat_5t");
    upd(32'h40, T_COND, 1'b0, 1'b0, 32'h10, 1'b0);
    look(32'h40, 1'b1, 32'h10, "sat_nt1");
    upd(32'h40, T_COND, 1'b0, 1'b0, 32'h10, 1'b0);
    look(32'h40, 1'b0, 32'h41, "sat_nt2");

    // upd_valid low: taken updates presented but ignored
    set_upd(32'h40, T_COND, 1'b0, 1'b1, 32'h10, 1'b1);
    upd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    look(32'h40, 1'b0, 32'h41, "freeze");

    // Not-taken branch that misses must not replace an existing entry
    upd(32'h05, T_JUMP, 1'b0, 1'b1, 32'h77, 1'b0);
    look(32'h05, 1'b1, 32'h77, "jump_alloc");
    upd(32'h45, T_COND, 1'b0, 1'b0, 32'h99, 1'b0);
    look(32'h05, 1'b1, 32'h77, "no_alloc_keep");
    look(32'h45, 1'b0, 32'h46, "no_alloc_miss");

    // RAS: return entry at 0x3A0 (pop on empty ignored), 9 calls, 8 pops
    upd(32'h3A0, T_RET, 1'b0, 1'b1, 32'h0, 1'b0);
    look(32'h3A0, 1'b0, 32'h3A1, "ras_empty0");
    for (int i = 0; i < 9; i++) upd(32'h100 + i, T_JUMP, 1'b1, 1'b1, 32'h500, 1'b0);
    for (int i = 0; i < 8; i++) begin
      look(32'h3A0, 1'b1, 32'h109 - i, "ras_pop");
      upd(32'h3A0, T_RET, 1'b0, 1'b1, 32'h109 - i, 1'b0);
    end
    look(32'h3A0, 1'b0, 32'h3A1, "ras_empty8");
    upd(32'h3A0, T_RET, 1'b0, 1'b1, 32'h0, 1'b0);
    look(32'h3A0, 1'b0, 32'h3A1, "ras_pop_empty");

    // Call+return together replaces the top without changing the count
    upd(32'h54, T_JUMP, 1'b1, 1'b1, 32'h500, 1'b0);
    look(32'h3A0, 1'b1, 32'h55, "ras_top55");
    upd(32'h200, T_RET, 1'b1, 1'b1, 32'h55, 1'b0);
    look(32'h3A0, 1'b1, 32'h201, "ras_replace");
    upd(32'h3A0, T_RET, 1'b0, 1'b1, 32'h201, 1'b0);
    look(32'h3A0, 1'b0, 32'h3A1, "ras_count1");

    // Perf counters from a clean reset
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rst2_perf_br", perf_branches, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    upd(32'h80, T_COND, 1'b0, 1'b1, 32'h20, 1'b1);
    upd(32'h80, T_COND, 1'b0, 1'b0, 32'h20, 1'b0);
    upd(32'h80, T_COND, 1'b0, 1'b1, 32'h20, 1'b1);
    upd(32'h05, T_JUMP, 1'b0, 1'b1, 32'h77, 1'b0);
    chk("perf_br3", perf_branches, 32'd3);
    chk("perf_mis2", perf_mispredicts, 32'd2);
    look(32'h05, 1'b1, 32'h77, "pre_rst_jump");

    // Asynchronous reset mid-cycle, with a pending update discarded
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_perf_br", perf_branches, 32'd0);
    chk("async_perf_mis", perf_mispredicts, 32'd0);
    look(32'h05, 1'b0, 32'h06, "async_btb");
    set_upd(32'h07, T_JUMP, 1'b0, 1'b1, 32'h33, 1'b1);
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    look(32'h07, 1'b0, 32'h08, "rst_discard");
    chk("rst_discard_mis", perf_mispredicts, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
